aclk_multi_alarm_ctrl: RTL and testbench

ACLK_MULTI_ALARM_CTRL -- requirements
Module: aclk_multi_alarm_ctrl

---
 rtl/aclk_pkg.sv | 28 ++
 rtl/aclk_sec_timer.sv | 31 +++
 rtl/aclk_multi_alarm_ctrl.sv | 156 +++++++++++++++
 tb/tb_aclk_multi_alarm_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad controller.
// Holds the state encoding, the idle key code and the width helper functions.
package aclk_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [3:0] NOKEY_CODE = 4'd10;

  // Six bits hold any legal timeout value (up to 63 seconds).
  localparam int TIMER_W = 6;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aclk_sec_timer.sv
// Inactivity timer for keypad entry: counts one_second pulses while enabled
// and holds at TIMEOUT_SEC instead of wrapping.
module aclk_sec_timer
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic time_out
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_SEC);

  logic [TIMER_W-1:0] r_count;

  // Clear takes priority over a coincident pulse so a fresh state starts at zero.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && one_second && (r_count != LIMIT)) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign time_out = (r_count == LIMIT);

endmodule

// File: rtl/aclk_multi_alarm_ctrl.sv
// Keypad/display controller for a multi-alarm clock: collects key digits,
// commits them to an alarm slot or the current time, and abandons idle entries.
module aclk_multi_alarm_ctrl
  import aclk_pkg::*;
#(
  parameter int         NUM_ALARMS  = 4,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         DIGITS      = 4,
  parameter logic [3:0] NOKEY       = NOKEY_CODE,
  localparam int        AW          = idx_width(NUM_ALARMS),
  localparam int        DW          = cnt_width(DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [3:0]            key,
  input  logic [AW-1:0]         alarm_sel,
  output logic                  show_new_time,
  output logic                  show_a,
  output logic                  shift,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic                  clear_entry,
  output logic [AW-1:0]         alarm_idx,
  output logic [DW-1:0]         digit_cnt
);

  localparam logic [DW-1:0] DIGITS_MAX = DW'(DIGITS);

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_digit_cnt;
  logic [AW-1:0]   r_alarm_idx;
  logic            r_clear_entry;
  logic            w_time_out;
  logic            w_key_idle;
  logic            w_full;
  logic            w_state_change;
  logic            w_timeout_exit;
  logic            w_timer_en;
  logic [AW-1:0]   w_sel_safe;

  assign w_key_idle     = (key == NOKEY);
  assign w_full         = (r_digit_cnt >= DIGITS_MAX);
  assign w_state_change = (w_next != r_state);
  assign w_timer_en     = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);
  assign w_sel_safe     = (int'(alarm_sel) < NUM_ALARMS) ? alarm_sel : '0;

  aclk_sec_timer #(
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_sec_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_state_change),
    .enable     (w_timer_en),
    .one_second (one_second),
    .time_out   (w_time_out)
  );

  // Commit buttons only count once a full entry is buffered; until then they
  // fall through to the timeout and key checks as if unpressed.
  always_comb begin
    w_next         = r_state;
    w_timeout_exit = 1'b0;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button)    w_next = SHOW_ALARM;
        else if (!w_key_idle) w_next = KEY_STORED;
      end
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: begin
        if (w_key_idle) begin
          w_next = KEY_ENTRY;
        end else if (w_time_out) begin
          w_next         = SHOW_TIME;
          w_timeout_exit = 1'b1;
        end
      end
      KEY_ENTRY: begin
        if (w_full && alarm_button) begin
          w_next = SET_ALARM_TIME;
        end else if (w_full && time_button) begin
          w_next = SET_CURRENT_TIME;
        end else if (w_time_out) begin
          w_next         = SHOW_TIME;
          w_timeout_exit = 1'b1;
        end else if (!w_key_idle) begin
          w_next = KEY_STORED;
        end
      end
      SHOW_ALARM: begin
        if (!alarm_button) w_next = SHOW_TIME;
      end
      SET_ALARM_TIME:   w_next = SHOW_TIME;
      SET_CURRENT_TIME: w_next = SHOW_TIME;
      default:          w_next = SHOW_TIME;
    endcase
  end

  always_comb begin
    show_new_time = 1'b0;
    show_a        = 1'b0;
    shift         = 1'b0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    load_new_a    = '0;
    case (r_state)
      KEY_STORED: begin
        show_new_time = 1'b1;
        shift         = !w_full;
      end
      KEY_WAITED, KEY_ENTRY: show_new_time = 1'b1;
      SHOW_ALARM:            show_a        = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      SET_ALARM_TIME: begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
          load_new_a[i] = (r_alarm_idx == AW'(i));
        end
      end
      default: ;
    endcase
  end

  // The slot index is captured on entry so a moving selector cannot retarget
  // an alarm that is already being shown or committed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= SHOW_TIME;
      r_digit_cnt   <= '0;
      r_alarm_idx   <= '0;
      r_clear_entry <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_clear_entry <= w_timeout_exit;
      if (w_next == SHOW_TIME) begin
        r_digit_cnt <= '0;
      end else if ((r_state == KEY_STORED) && !w_full) begin
        r_digit_cnt <= r_digit_cnt + DW'(1);
      end
      if (w_state_change && ((w_next == SHOW_ALARM) || (w_next == SET_ALARM_TIME))) begin
        r_alarm_idx <= w_sel_safe;
      end
    end
  end

  assign clear_entry = r_clear_entry;
  assign alarm_idx   = r_alarm_idx;
  assign digit_cnt   = r_digit_cnt;

endmodule

// File: tb/tb_aclk_multi_alarm_ctrl.sv
// Self-checking bench for aclk_multi_alarm_ctrl: directed scenarios plus random
// keypad traffic, both checked every cycle against a behavioural model.
module tb_aclk_multi_alarm_ctrl;

  localparam int         NA = 4;
  localparam int         NB = 5;
  localparam int         TO = 10;
  localparam int         DG = 4;
  localparam logic [3:0] NK = 4'd10;

  typedef enum int {M_IDLE, M_STORED, M_WAITED, M_ENTRY, M_VIEW, M_COMMIT_ALARM, M_COMMIT_TIME} mode_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] key = NK;
  logic [2:0] selWide = 3'd0;
  logic [1:0] selNarrow;

  logic          showNewA, showAA, shiftA, loadCA, resetCountA, clearA;
  logic [NA-1:0] loadAA;
  logic [1:0]    idxA;
  logic [2:0]    digA;
  logic          showNewB, showAB, shiftB, loadCB, resetCountB, clearB;
  logic [NB-1:0] loadAB;
  logic [2:0]    idxB;
  logic [2:0]    digB;

  int total = 0;
  int bad = 0;

  mode_t mMode = M_IDLE;
  int    mSecs = 0;
  int    mDigits = 0;
  int    mIdxA = 0;
  int    mIdxB = 0;
  bit    mClear = 1'b0;

  int          shiftCount = 0;
  int          loadACount = 0;
  int          loadCCount = 0;
  int          clearCount = 0;
  int          strobeCount = 0;
  logic [3:0]  lastLoadA = '0;
  logic [4:0]  lastLoadB = '0;

  assign selNarrow = selWide[1:0];

  always #5 clock = ~clock;

  aclk_multi_alarm_ctrl #(
    .NUM_ALARMS (NA), .TIMEOUT_SEC (TO), .DIGITS (DG), .NOKEY (NK)
  ) dutA (
    .clock (clock), .reset (reset), .one_second (one_second),
    .alarm_button (alarm_button), .time_button (time_button), .key (key),
    .alarm_sel (selNarrow), .show_new_time (showNewA), .show_a (showAA),
    .shift (shiftA), .load_new_a (loadAA), .load_new_c (loadCA),
    .reset_count (resetCountA), .clear_entry (clearA), .alarm_idx (idxA),
    .digit_cnt (digA)
  );

  // A 2-bit selector cannot express an out-of-range slot, so a five-slot copy
  // on a 3-bit selector exercises the clamp to slot 0.
  aclk_multi_alarm_ctrl #(
    .NUM_ALARMS (NB), .TIMEOUT_SEC (TO), .DIGITS (DG), .NOKEY (NK)
  ) dutB (
    .clock (clock), .reset (reset), .one_second (one_second),
    .alarm_button (alarm_button), .time_button (time_button), .key (key),
    .alarm_sel (selWide), .show_new_time (showNewB), .show_a (showAB),
    .shift (shiftB), .load_new_a (loadAB), .load_new_c (loadCB),
    .reset_count (resetCountB), .clear_entry (clearB), .alarm_idx (idxB),
    .digit_cnt (digB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: what the controller should be doing after each edge,
  // derived from the keypad rules rather than from the RTL structure.
  always @(posedge clock) begin : model
    mode_t nxt;
    bit    timedOut;
    bit    full;
    bit    keyDown;
    if (reset) begin
      mMode = M_IDLE; mSecs = 0; mDigits = 0; mIdxA = 0; mIdxB = 0; mClear = 1'b0;
    end else begin
      nxt      = mMode;
      timedOut = (mSecs >= TO);
      full     = (mDigits >= DG);
      keyDown  = (key != NK);
      mClear   = 1'b0;
      case (mMode)
        M_IDLE:   nxt = alarm_button ? M_VIEW : (keyDown ? M_STORED : M_IDLE);
        M_STORED: nxt = M_WAITED;
        M_WAITED: begin
          if (!keyDown) nxt = M_ENTRY;
          else if (timedOut) begin nxt = M_IDLE; mClear = 1'b1; end
        end
        M_ENTRY: begin
          if (full && alarm_button) nxt = M_COMMIT_ALARM;
          else if (full && time_button) nxt = M_COMMIT_TIME;
          else if (timedOut) begin nxt = M_IDLE; mClear = 1'b1; end
          else if (keyDown) nxt = M_STORED;
        end
        M_VIEW:   nxt = alarm_button ? M_VIEW : M_IDLE;
        default:  nxt = M_IDLE;
      endcase
      if (mMode == M_STORED && mDigits < DG) mDigits = mDigits + 1;
      if (nxt != mMode) begin
        mSecs = 0;
        if (nxt == M_VIEW || nxt == M_COMMIT_ALARM) begin
          mIdxA = int'(selWide) % NA;
          mIdxB = (int'(selWide) < NB) ? int'(selWide) : 0;
        end
      end else if ((mMode == M_WAITED || mMode == M_ENTRY) && one_second && mSecs < TO) begin
        mSecs = mSecs + 1;
      end
      if (nxt == M_IDLE) mDigits = 0;
      mMode = nxt;
    end
  end

  // Compare on the falling edge, and tally strobes for the directed scenarios.
  always @(negedge clock) begin : compare
    logic entryShown;
    logic expShift;
    logic expLoadC;
    entryShown = (mMode == M_STORED || mMode == M_WAITED || mMode == M_ENTRY);
    expShift   = (mMode == M_STORED) && (mDigits < DG);
    expLoadC   = (mMode == M_COMMIT_TIME);
    checkOutput("A.show_new_time", 32'(showNewA), 32'(entryShown));
    checkOutput("A.show_a", 32'(showAA), 32'(mMode == M_VIEW));
    checkOutput("A.shift", 32'(shiftA), 32'(expShift));
    checkOutput("A.load_new_c", 32'(loadCA), 32'(expLoadC));
    checkOutput("A.reset_count", 32'(resetCountA), 32'(expLoadC));
    checkOutput("A.clear_entry", 32'(clearA), 32'(mClear));
    checkOutput("A.load_new_a", 32'(loadAA), (mMode == M_COMMIT_ALARM) ? (32'd1 << mIdxA) : 32'd0);
    checkOutput("A.alarm_idx", 32'(idxA), 32'(mIdxA));
    checkOutput("A.digit_cnt", 32'(digA), 32'(mDigits));
    checkOutput("B.show_new_time", 32'(showNewB), 32'(entryShown));
    checkOutput("B.show_a", 32'(showAB), 32'(mMode == M_VIEW));
    checkOutput("B.shift", 32'(shiftB), 32'(expShift));
    checkOutput("B.load_new_c", 32'(loadCB), 32'(expLoadC));
    checkOutput("B.reset_count", 32'(resetCountB), 32'(expLoadC));
    checkOutput("B.clear_entry", 32'(clearB), 32'(mClear));
    checkOutput("B.load_new_a", 32'(loadAB), (mMode == M_COMMIT_ALARM) ? (32'd1 << mIdxB) : 32'd0);
    checkOutput("B.alarm_idx", 32'(idxB), 32'(mIdxB));
    checkOutput("B.digit_cnt", 32'(digB), 32'(mDigits));
    if (shiftA) shiftCount++;
    if (|loadAA) begin loadACount++; lastLoadA = loadAA; end
    if (|loadAB) lastLoadB = loadAB;
    if (loadCA) loadCCount++;
    if (clearA) clearCount++;
    if ((|loadAA) || loadCA || resetCountA) strobeCount++;
  end

  // Inputs change 1 time unit after the falling edge, clear of both edges.
  task automatic applyStimulus(input logic ab, input logic tb, input logic [3:0] k,
                               input logic [2:0] sel, input logic os, input logic rst);
    alarm_button = ab;
    time_button  = tb;
    key          = k;
    selWide      = sel;
    one_second   = os;
    reset        = rst;
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] sel);
    repeat (n) applyStimulus(1'b0, 1'b0, NK, sel, 1'b0, 1'b0);
  endtask

  task automatic pressKey(input logic [3:0] k, input logic [2:0] sel);
    repeat (2) applyStimulus(1'b0, 1'b0, k, sel, 1'b0, 1'b0);
    idle(2, sel);
  endtask

  task automatic secPulses(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 1'b0, NK, selWide, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, NK, selWide, 1'b0, 1'b0);
    end
  endtask

  initial begin : stimulus
    int s0, l0, c0, k0, t0;
    int holdLeft;
    logic [3:0] curKey;

    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset.show_new_time", 32'(showNewA), 32'd0);
    checkOutput("reset.digit_cnt", 32'(digA), 32'd0);
    checkOutput("reset.alarm_idx", 32'(idxA), 32'd0);
    checkOutput("reset.strobes", 32'({loadAA, loadCA, clearA, shiftA}), 32'd0);
    idle(2, 3'd0);

    // Full entry committed to slot 2.
    s0 = shiftCount; l0 = loadACount;
    pressKey(4'd1, 3'd2); pressKey(4'd2, 3'd2); pressKey(4'd3, 3'd2); pressKey(4'd4, 3'd2);
    checkOutput("alarm2.digit_cnt", 32'(digA), 32'd4);
    checkOutput("alarm2.shifts", 32'(shiftCount - s0), 32'd4);
    applyStimulus(1'b1, 1'b0, NK, 3'd2, 1'b0, 1'b0);
    idle(3, 3'd2);
    checkOutput("alarm2.loads", 32'(loadACount - l0), 32'd1);
    checkOutput("alarm2.load_new_a", 32'(lastLoadA), 32'b0100);
    checkOutput("alarm2.alarm_idx", 32'(idxA), 32'd2);
    checkOutput("alarm2.digit_after", 32'(digA), 32'd0);

    // Partial entry: time button ignored, then timeout discards it.
    c0 = loadCCount; k0 = clearCount;
    pressKey(4'd7, 3'd0); pressKey(4'd8, 3'd0);
    repeat (2) applyStimulus(1'b0, 1'b1, NK, 3'd0, 1'b0, 1'b0);
    checkOutput("partial.still_entry", 32'(showNewA), 32'd1);
    checkOutput("partial.no_load_c", 32'(loadCCount - c0), 32'd0);
    secPulses(9);
    checkOutput("partial.nine_sec", 32'({showNewA, 3'(clearCount - k0)}), 32'b1000);
    secPulses(1);
    idle(2, 3'd0);
    checkOutput("partial.clears", 32'(clearCount - k0), 32'd1);
    checkOutput("partial.show_time", 32'(showNewA), 32'd0);

    // Key held for 12 seconds times out of KEY_WAITED, then restarts.
    k0 = clearCount; s0 = shiftCount;
    repeat (12) begin
      applyStimulus(1'b0, 1'b0, 4'd5, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd5, 3'd0, 1'b0, 1'b0);
    end
    checkOutput("held.clears", 32'(clearCount - k0), 32'd1);
    checkOutput("held.shifts", 32'(shiftCount - s0), 32'd2);
    applyStimulus(1'b0, 1'b0, NK, 3'd0, 1'b0, 1'b1);
    idle(1, 3'd0);

    // Both buttons together: alarm commit wins.
    l0 = loadACount; c0 = loadCCount;
    pressKey(4'd0, 3'd1); pressKey(4'd9, 3'd1); pressKey(4'd3, 3'd1); pressKey(4'd1, 3'd1);
    applyStimulus(1'b1, 1'b1, NK, 3'd1, 1'b0, 1'b0);
    idle(3, 3'd1);
    checkOutput("both.loads", 32'(loadACount - l0), 32'd1);
    checkOutput("both.load_new_a", 32'(lastLoadA), 32'b0010);
    checkOutput("both.no_load_c", 32'(loadCCount - c0), 32'd0);

    // Reset mid-entry aborts silently.
    pressKey(4'd2, 3'd1); pressKey(4'd2, 3'd1); pressKey(4'd2, 3'd1);
    checkOutput("abort.digit_cnt", 32'(digA), 32'd3);
    applyStimulus(1'b1, 1'b1, NK, 3'd1, 1'b0, 1'b1);
    checkOutput("abort.outputs", 32'({showNewA, showAA, shiftA, loadAA, loadCA, resetCountA, clearA}), 32'd0);
    checkOutput("abort.idx_digits", 32'({idxA, digA}), 32'd0);
    t0 = strobeCount;
    idle(2, 3'd1);
    checkOutput("abort.no_strobe", 32'(strobeCount - t0), 32'd0);

    // Six digits saturate at four; selector 7 is clamped on the wide copy.
    applyStimulus(1'b1, 1'b0, NK, 3'd3, 1'b0, 1'b0);
    idle(2, 3'd3);
    checkOutput("view.idxB", 32'(idxB), 32'd3);
    s0 = shiftCount;
    for (int i = 0; i < 6; i++) pressKey(4'(i + 1), 3'd7);
    checkOutput("six.shifts", 32'(shiftCount - s0), 32'd4);
    checkOutput("six.digit_cnt", 32'(digA), 32'd4);
    applyStimulus(1'b1, 1'b0, NK, 3'd7, 1'b0, 1'b0);
    idle(3, 3'd7);
    checkOutput("clamp.idxB", 32'(idxB), 32'd0);
    checkOutput("clamp.load_new_aB", 32'(lastLoadB), 32'b00001);
    checkOutput("clamp.idxA", 32'(idxA), 32'd3);
    checkOutput("clamp.load_new_aA", 32'(lastLoadA), 32'b1000);

    // Random keypad traffic, checked by the compare process every cycle.
    holdLeft = 0;
    curKey   = NK;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (holdLeft == 0) begin
        curKey   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NK;
        holdLeft = $urandom_range(1, 8);
      end
      holdLeft--;
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, curKey,
                    3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 299) == 0);
    end

    idle(2, 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
